// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    // Word index width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned word_idx_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH_WORDS x 32 word store: byte-enabled synchronous write, registered read on the same edge.
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = word_idx_width(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding word load/store with
// configurable wait states, alignment and range checking in front of a word array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = word_idx_width(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        err_q;
    logic        load_q;

    logic        enter_resp;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [31:0] acc_off;
    logic        acc_err;
    logic        arr_en;
    logic [31:0] arr_rdata;

    // With zero wait states the array is accessed on the accept edge, before the
    // latch holds the request, so the access port reads the live request in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_write = lat_write;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_err = (acc_off[1:0] != 2'b00) || ({2'b00, acc_off[31:2]} >= DEPTH_WORDS);
    end

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt_q     <= 4'(WAIT_CYCLES);
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                err_q  <= acc_err;
                load_q <= !acc_write && !acc_err;
            end
        end
    end

    // Reset must also block a store whose commit edge coincides with rst.
    assign arr_en = enter_resp && !acc_err && !rst;

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (acc_write),
        .be    (acc_be),
        .idx   (acc_off[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = ((state_q == ST_RESP) && load_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance for directed
// vectors and corner sequences, a WAIT_CYCLES=0 instance for a random model-checked stream.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int unsigned DEPTH0 = 256;
    localparam int unsigned W0     = 2;
    localparam int unsigned DEPTH1 = 64;
    localparam int unsigned W1     = 0;
    localparam logic [31:0] BASE1  = 32'h8000_0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_write, rsp_ready;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][3:0]  req_be;

    logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [31:0] rsp_rdata0, rsp_rdata1;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH0),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (W0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready0), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    dmem_responder #(
        .DEPTH_WORDS (DEPTH1),
        .BASE_ADDR   (BASE1),
        .WAIT_CYCLES (W1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready1), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb_q[$];
    logic [31:0] model1 [DEPTH1];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic get_ready(input int d);
        return (d == 0) ? req_ready0 : req_ready1;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 0) ? rsp_valid0 : rsp_valid1;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? rsp_err0 : rsp_err1;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? rsp_rdata0 : rsp_rdata1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT, expected handshake", name);
    endtask

    // One full transaction: expected result pushed at drive time, popped at response handshake.
    task automatic do_txn(input int d, input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          input bit chk_rdy, input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        logic [32:0] e;
        sb_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        for (int i = 0; i < 20 && !get_ready(d); i++) @(negedge clk);
        if (!get_ready(d)) begin
            fail_timeout({tag, ".req_ready"});
            req_valid[d] = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!get_valid(d) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!get_valid(d)) begin
            fail_timeout({tag, ".rsp_valid"});
            void'(sb_q.pop_front());
            return;
        end
        check({tag, ".latency"}, 32'(lat), (d == 0) ? 32'(W0 + 1) : 32'(W1 + 1));
        e = sb_q[0];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(get_valid(d)), 32'd1);
            check({tag, ".hold_rdata"}, get_rdata(d), e[31:0]);
            check({tag, ".hold_err"},   32'(get_err(d)), 32'(e[32]));
            check({tag, ".hold_req_ready"}, 32'(get_ready(d)), 32'd0);
        end
        @(negedge clk);
        e = sb_q.pop_front();
        check({tag, ".rdata"}, get_rdata(d), e[31:0]);
        check({tag, ".err"},   32'(get_err(d)), 32'(e[32]));
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        if (chk_rdy) begin
            check({tag, ".req_ready_after"}, 32'(get_ready(d)), 32'd1);
            check({tag, ".rsp_valid_after"}, 32'(get_valid(d)), 32'd0);
        end
    endtask

    // Reference model for the second instance; independent of the RTL's index arithmetic.
    task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int hold);
        logic [31:0] off;
        logic        err;
        logic [31:0] exp;
        int unsigned wi;
        off = addr - BASE1;
        err = (addr[1:0] != 2'b00) || (off >= 32'(4 * DEPTH1));
        exp = '0;
        if (!err) begin
            wi = off / 4;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model1[wi][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp = model1[wi];
            end
        end
        do_txn(1, "rand", wr, addr, wdata, be, hold, 1'b0, exp, err);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          k;
        rst = 1'b1;
        req_valid = '0; req_write = '0; rsp_ready = '0;
        req_addr = '0; req_wdata = '0; req_be = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.rsp_valid0", 32'(rsp_valid0), 32'd0);
        check("reset.rsp_rdata0", rsp_rdata0, 32'd0);
        check("reset.rsp_err0",   32'(rsp_err0), 32'd0);
        check("reset.rsp_valid1", 32'(rsp_valid1), 32'd0);
        check("reset.rsp_rdata1", rsp_rdata1, 32'd0);
        check("reset.rsp_err1",   32'(rsp_err1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset.req_ready0", 32'(req_ready0), 32'd1);
        check("reset.req_ready1", 32'(req_ready1), 32'd1);

        // Directed vectors: {wr, addr, wdata, be, exp_rdata, exp_err}
        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h20,  32'hAAAAAAAA, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h20,  32'h11223344, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h20,  32'h0,        4'hF, 32'hAA22AA44, 1'b0});
        vecs.push_back('{1'b0, 32'h13,  32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 32'h24,  32'h01020304, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h24,  32'hCAFEF00D, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h24,  32'h0,        4'hF, 32'h01020304, 1'b0});
        vecs.push_back('{1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        foreach (vecs[i])
            do_txn(0, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].be, 0, 1'b1, vecs[i].exp_rdata, vecs[i].exp_err);

        // Response back-pressure, then back-to-back requests
        do_txn(0, "hold",  1'b0, 32'h10, 32'h0,        4'hF, 5, 1'b1, 32'hDEADBEEF, 1'b0);
        do_txn(0, "b2b_w", 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 0, 1'b1, 32'h0,        1'b0);
        do_txn(0, "b2b_r", 1'b0, 32'h40, 32'h0,        4'hF, 0, 1'b1, 32'h0BADF00D, 1'b0);

        // Reset on the would-be commit edge of a store discards it
        do_txn(0, "rst_pre", 1'b1, 32'h30, 32'h0, 4'hF, 0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h55; req_be[0] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("rst.in_wait_valid", 32'(rsp_valid0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst.rsp_valid", 32'(rsp_valid0), 32'd0);
        check("rst.req_ready", 32'(req_ready0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.quiet_valid", 32'(rsp_valid0), 32'd0);
        do_txn(0, "rst_load", 1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b1, 32'h0, 1'b0);

        // Zero-wait instance: known contents, then a random stream against the model
        for (int w = 0; w < int'(DEPTH1); w++)
            model_txn(1'b1, BASE1 + 32'(4 * w), 32'h0, 4'hF, 0);
        for (int t = 0; t < 10000; t++) begin
            k = $urandom_range(0, 9);
            a = BASE1 + 32'(4 * $urandom_range(0, DEPTH1 - 1));
            if (k == 0)      a = a + 32'($urandom_range(1, 3));
            else if (k == 1) a = BASE1 + 32'(4 * DEPTH1) + 32'(4 * $urandom_range(0, 1000));
            else if (k == 2) a = BASE1 - 32'(4 * $urandom_range(1, 100));
            model_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
